sprite_line_buffer: RTL

- Double-buffered sprite line buffer directly downstream of the video timing generator; consumes its pixel enable, hc, vc, hbl and vbl.
- The sprite engine writes pixels for line N+1 into one bank while the other bank is scanned out at hc for line N.
- Banks swap at the start of horizontal blanking.
- Displayed pixels are cleared after read, so each bank is empty when it becomes the write bank again.

---
 rtl/sprite_line_buffer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/sprite_line_buffer.sv
// Double-buffered sprite line buffer: sprite engine fills one bank while the other is scanned out.
// Latency: scan-out one pixel (one clk_pix); sprite writes commit same clk (two clk with LINEBUF_PRIO_EN).
// Backpressure: none; one write accepted per clk. Optional macro LINEBUF_PRIO_EN adds per-pixel priority merge.
module sprite_line_buffer #(
    parameter int DW       = 12,
    parameter int PEN_BITS = 4,
    parameter int LINE_W   = 320
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clk_pix,
    input  logic [8:0]    hc,
    input  logic [8:0]    vc,
    input  logic          hbl,
    input  logic          vbl,
    input  logic          wr_en,
    input  logic [8:0]    wr_x,
    input  logic [DW-1:0] wr_data,
    input  logic [1:0]    wr_prio,
    output logic          init_done,
    output logic          line_start,
    output logic [8:0]    line_y,
    output logic [DW-1:0] pix_out
);

    localparam logic [8:0] X_END = 9'(LINE_W);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t        state;
    logic [8:0]    addr;
    logic          bank;
    logic          hbl_d;
    logic          clr_vld;
    logic          clr_bank;
    logic [8:0]    clr_addr;

    logic [DW-1:0] mem [2][LINE_W];

    logic          swap;
    logic          scan_active;
    logic          wr_acc;

    // A swap is the first clk_pix cycle of horizontal blanking; never during the post-reset clear.
    assign swap        = (state == S_RUN) && clk_pix && hbl && !hbl_d;
    assign scan_active = !(hbl || vbl) && (hc < X_END);
    assign wr_acc      = (state == S_RUN) && wr_en && (wr_x < X_END)
                         && (wr_data[PEN_BITS-1:0] != '0);

    // Control FSM, bank swap, scan-out register and clear-after-read scheduling.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_CLEAR;
            addr       <= '0;
            init_done  <= 1'b0;
            bank       <= 1'b0;
            hbl_d      <= 1'b0;
            pix_out    <= '0;
            line_start <= 1'b0;
            line_y     <= '0;
            clr_vld    <= 1'b0;
            clr_bank   <= 1'b0;
            clr_addr   <= '0;
        end else begin
            line_start <= 1'b0;
            clr_vld    <= 1'b0;
            if (clk_pix) begin
                hbl_d <= hbl;
            end
            case (state)
                S_CLEAR: begin
                    if (addr == X_END - 9'd1) begin
                        state     <= S_RUN;
                        init_done <= 1'b1;
                    end else begin
                        addr <= addr + 9'd1;
                    end
                end
                S_RUN: begin
                    if (clk_pix) begin
                        if (swap) begin
                            bank       <= ~bank;
                            line_start <= 1'b1;
                            line_y     <= vc + 9'd1;
                        end
                        if (scan_active) begin
                            // Read and clear use the pre-swap display bank.
                            pix_out  <= mem[bank][hc];
                            clr_vld  <= 1'b1;
                            clr_bank <= bank;
                            clr_addr <= hc;
                        end else begin
                            pix_out <= '0;
                        end
                    end
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

`ifdef LINEBUF_PRIO_EN
    logic [1:0]    pmem [2][LINE_W];

    logic          s_vld;
    logic          s_bank;
    logic [8:0]    s_x;
    logic [DW-1:0] s_data;
    logic [1:0]    s_prio;
    logic [DW-1:0] s_odata;
    logic [1:0]    s_oprio;
    logic          s_win;
    logic          fwd;

    // Stage 2 commits over an empty slot or a strictly lower priority; ties keep the first writer.
    assign s_win = s_vld && ((s_odata[PEN_BITS-1:0] == '0) || (s_prio > s_oprio));
    // Stage 1 must see a commit to the same slot happening in this clk.
    assign fwd   = s_vld && (s_bank == ~bank) && (s_x == wr_x);

    // Write pipeline: stage 1 captures the request and the current slot contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_vld <= 1'b0;
        end else begin
            s_vld <= wr_acc;
        end
        s_bank <= ~bank;
        s_x    <= wr_x;
        s_data <= wr_data;
        s_prio <= wr_prio;
        if (fwd) begin
            s_odata <= s_win ? s_data : s_odata;
            s_oprio <= s_win ? s_prio : s_oprio;
        end else if (wr_x < X_END) begin
            s_odata <= mem[~bank][wr_x];
            s_oprio <= pmem[~bank][wr_x];
        end else begin
            s_odata <= '0;
            s_oprio <= '0;
        end
    end

    // Memory writes: full clear, clear-after-read, and priority-merged sprite commits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == S_CLEAR) begin
                mem[0][addr]  <= '0;
                mem[1][addr]  <= '0;
                pmem[0][addr] <= '0;
                pmem[1][addr] <= '0;
            end else begin
                if (clr_vld) begin
                    mem[clr_bank][clr_addr]  <= '0;
                    pmem[clr_bank][clr_addr] <= '0;
                end
                if (s_win) begin
                    mem[s_bank][s_x]  <= s_data;
                    pmem[s_bank][s_x] <= s_prio;
                end
            end
        end
    end
`else
    logic unused_prio;
    assign unused_prio = ^wr_prio;

    // Memory writes: full clear, clear-after-read, and last-opaque-writer-wins sprite commits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == S_CLEAR) begin
                mem[0][addr] <= '0;
                mem[1][addr] <= '0;
            end else begin
                if (clr_vld) begin
                    mem[clr_bank][clr_addr] <= '0;
                end
                if (wr_acc) begin
                    mem[~bank][wr_x] <= wr_data;
                end
            end
        end
    end
`endif

endmodule
